// File: rtl/int_div_var_pkg.sv
// Shared types and sizing helpers for the variable-latency iterative divider.
package int_div_var_pkg;

  // Controller states: accept a request, iterate restoring steps, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the iteration counter and leading-zero count: must hold 0..NBITS.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

  // Count width for the default 32-bit operand size.
  localparam int CNT_W = $clog2(32) + 1;

endpackage

// File: rtl/int_div_var_calc_lz.sv
// Combinational leading-zero counter: returns NBITS for an all-zero input.
module int_div_var_calc_lz
  import int_div_var_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int CW    = cnt_width(NBITS)
) (
  input  logic [NBITS-1:0] value_i,
  output logic [CW-1:0]    count_o
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    count_o = CW'(NBITS);
    found   = 1'b0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (!found && value_i[i]) begin
        count_o = CW'(NBITS - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_div_var.sv
// Variable-latency unsigned restoring divider. Leading zeros of the dividend
// are skipped up front, so the iteration count equals its significant width.
//
// Handshake: a transfer happens on a rising clk edge where val and rdy are
// both high; a producer raises val without waiting for rdy, and holds msg
// stable while val is high and rdy is low. The response (ostream_msg) is held
// stable while ostream_val is high and ostream_rdy is low.
module int_div_var
  import int_div_var_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);

  localparam int CW = cnt_width(NBITS);

  state_e            state_q;
  logic [NBITS-1:0]  a_q, b_q, r_q, q_q;
  logic [CW-1:0]     cnt_q;
  // Set for divide-by-zero and zero dividend: the result is already final, the
  // single CALC cycle only paces the response to the common one-cycle minimum.
  logic              hold_q;

  logic [NBITS-1:0]  a_in, b_in;
  logic [CW-1:0]     lz;
  logic [NBITS:0]    t_d, diff_d;
  logic              ge_d;
  logic [NBITS-1:0]  r_d, q_d, a_shift_d;
  logic              req_xfer, rsp_xfer;

  assign a_in = istream_msg[2*NBITS-1:NBITS];
  assign b_in = istream_msg[NBITS-1:0];

  int_div_var_calc_lz #(
    .NBITS (NBITS),
    .CW    (CW)
  ) u_calc_lz (
    .value_i (a_in),
    .count_o (lz)
  );

  // Handshake outputs decode directly from the state register.
  assign istream_rdy = (state_q == IDLE);
  assign ostream_val = (state_q == DONE);
  assign ostream_msg = {r_q, q_q};
  assign req_xfer    = istream_val && istream_rdy;
  assign rsp_xfer    = ostream_val && ostream_rdy;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits.
  always_comb begin
    t_d       = {r_q, a_q[NBITS-1]};
    diff_d    = t_d - {1'b0, b_q};
    ge_d      = (t_d >= {1'b0, b_q});
    r_d       = ge_d ? diff_d[NBITS-1:0] : t_d[NBITS-1:0];
    q_d       = {q_q[NBITS-2:0], ge_d};
    a_shift_d = a_in << lz;
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_xfer) begin
            a_q     <= a_shift_d;
            b_q     <= b_in;
            state_q <= CALC;
            if (b_in == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              r_q    <= a_in;
              q_q    <= '1;
              cnt_q  <= CW'(1);
              hold_q <= 1'b1;
            end else if (lz == CW'(NBITS)) begin
              r_q    <= '0;
              q_q    <= '0;
              cnt_q  <= CW'(1);
              hold_q <= 1'b1;
            end else begin
              r_q    <= '0;
              q_q    <= '0;
              cnt_q  <= CW'(NBITS) - lz;
              hold_q <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!hold_q) begin
            r_q <= r_d;
            q_q <= q_d;
            a_q <= a_q << 1;
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (rsp_xfer) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_var.sv
// Bench for int_div_var: table of divide vectors plus hand-written sequences
// for backpressure and reset abort; results flow through an expected queue.
module tb_int_div_var;

  localparam int NBITS = 32;

  logic               clk;
  logic               reset_n;
  logic               istream_val;
  logic               istream_rdy;
  logic [2*NBITS-1:0] istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [2*NBITS-1:0] ostream_msg;

  int checks;
  int errors;

  logic [2*NBITS-1:0] exp_q[$];
  int                 lat_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  int_div_var #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Independent reference: plain / and %, latency from the dividend MSB.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    if (a == 0 || b == 0) return 1;
    for (int i = 31; i >= 0; i--) if (a[i]) return i + 1;
    return 1;
  endfunction

  function automatic logic [63:0] model_rsp(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Driver: send one request and push its expected response.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int waitc;
    waitc = 0;
    while (istream_rdy !== 1'b1 && waitc < 100) begin
      @(posedge clk); #1; waitc++;
    end
    if (waitc >= 100) check("issue_rdy_timeout", 64'(istream_rdy), 64'd1);
    exp_q.push_back(model_rsp(a, b));
    lat_q.push_back(model_lat(a, b));
    istream_val = 1'b1;
    istream_msg = {a, b};
    @(posedge clk); #1;
    istream_val = 1'b0;
    // Scramble the bus: the DUT must have captured it on the transfer edge.
    istream_msg = {$urandom, $urandom};
    check("rdy_low_after_accept", 64'(istream_rdy), 64'd0);
  endtask

  // Monitor/scoreboard: wait for the response, check latency and value,
  // optionally hold off the sink for hold_cycles before accepting.
  task automatic collect(input string tag, input int hold_cycles);
    int lat;
    int el;
    logic [63:0] e;
    lat = 0;
    while (ostream_val !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(el));
    check({tag, "_msg"}, ostream_msg, e);
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      check({tag, "_bp_val"}, 64'(ostream_val), 64'd1);
      check({tag, "_bp_msg"}, ostream_msg, e);
      check({tag, "_bp_rdy"}, 64'(istream_rdy), 64'd0);
    end
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    check({tag, "_val_drop"}, 64'(ostream_val), 64'd0);
    check({tag, "_idle_rdy"}, 64'(istream_rdy), 64'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b1;

    vecs.push_back('{32'd7,          32'd2, 32'd3,          32'd1,   3});
    vecs.push_back('{32'd0,          32'd5, 32'd0,          32'd0,   1});
    vecs.push_back('{32'd100,        32'd0, 32'hFFFF_FFFF,  32'd100, 1});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1, 32'hFFFF_FFFF,  32'd0,   32});
    vecs.push_back('{32'h8000_0000,  32'd3, 32'h2AAA_AAAA,  32'd2,   32});
    vecs.push_back('{32'd1,          32'd1, 32'd1,          32'd0,   1});
    vecs.push_back('{32'd5,          32'd9, 32'd0,          32'd5,   3});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,  32'd0,   32});

    #12;
    check("reset_rdy", 64'(istream_rdy), 64'd1);
    check("reset_val", 64'(ostream_val), 64'd0);
    check("reset_msg", ostream_msg, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors: constants in the table cross-check the reference model.
    foreach (vecs[i]) begin
      check("table_model_rsp", model_rsp(vecs[i].a, vecs[i].b), {vecs[i].r, vecs[i].q});
      issue(vecs[i].a, vecs[i].b);
      collect("table", 0);
    end

    // Random operands, a few with narrowed dividends for short latencies.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      issue(ra, rb);
      collect("rand", 0);
    end

    // Backpressure: sink stalls 5 cycles after the response appears.
    ostream_rdy = 1'b0;
    issue(32'd1000, 32'd7);
    check("bp_model", exp_q[0], {32'd6, 32'd142});
    collect("bp", 5);

    // Reset abort in the middle of a long division.
    issue(32'hFFFF_0000, 32'd3);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_val", 64'(ostream_val), 64'd0);
    check("abort_rdy", 64'(istream_rdy), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 64'(ostream_val), 64'd0);
    end
    issue(32'd9, 32'd4);
    check("post_reset_model", exp_q[0], {32'd1, 32'd2});
    collect("post_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
